// File: rtl/move_pkg.sv
// ---------------------------------------------------------------------------
// move_pkg
// Shared definitions for the grid-cursor move sequencer.
//   - command layout {dir[1:0], step[1:0]} and its field widths
//   - direction encodings (+x, -x, +y, -y)
//   - FSM state encoding
//   - unit_step(): one-unit coordinate update. It saturates at the grid
//     edge and reports the clip. When MOVE_WRAP_EN is defined it wraps
//     modulo 16 instead and never reports a clip.
// ---------------------------------------------------------------------------
package move_pkg;

  localparam int CMD_W   = 4;
  localparam int COORD_W = 4;

  localparam logic [1:0] DIR_XP = 2'b00;
  localparam logic [1:0] DIR_XN = 2'b01;
  localparam logic [1:0] DIR_YP = 2'b10;
  localparam logic [1:0] DIR_YN = 2'b11;

  localparam logic [COORD_W-1:0] COORD_MIN = 4'd0;
  localparam logic [COORD_W-1:0] COORD_MAX = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MOVE = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0] dir;
    logic [1:0] step;
  } cmd_t;

  // Returns {clip, new_coord} for one unit move up (neg=0) or down (neg=1).
  function automatic logic [COORD_W:0] unit_step(input logic [COORD_W-1:0] c,
                                                 input logic               neg);
    logic [COORD_W-1:0] r;
    logic               clip;
`ifdef MOVE_WRAP_EN
    clip = 1'b0;
    if (neg) begin
      r = c - 4'd1;
    end else begin
      r = c + 4'd1;
    end
`else
    if (neg) begin
      if (c == COORD_MIN) begin
        r    = c;
        clip = 1'b1;
      end else begin
        r    = c - 4'd1;
        clip = 1'b0;
      end
    end else begin
      if (c == COORD_MAX) begin
        r    = c;
        clip = 1'b1;
      end else begin
        r    = c + 4'd1;
        clip = 1'b0;
      end
    end
`endif
    return {clip, r};
  endfunction

endpackage

// File: rtl/move_cmd_fifo.sv
// ---------------------------------------------------------------------------
// move_cmd_fifo
// Small synchronous command FIFO with no bypass path. A pushed word becomes
// visible on dout one cycle after the push edge at the earliest.
// A push while full and a pop while empty are both ignored.
// Ports:
//   clk    in   system clock (posedge)
//   rst_n  in   synchronous active-low reset, empties the FIFO
//   push   in   write din this cycle (honoured only when !full)
//   pop    in   drop the head this cycle (honoured only when !empty)
//   din    in   [W-1:0] write data
//   dout   out  [W-1:0] current head (valid when !empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
// ---------------------------------------------------------------------------
module move_cmd_fifo
  import move_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic         do_push_s;
  logic         do_pop_s;

  // The pointers carry one extra wrap bit that tells full apart from empty.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; a push and a pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; contents are don't-care until written, so there is no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// ---------------------------------------------------------------------------
// move_sequencer
// Command scheduler for a 4-bit x/y grid cursor. Move commands
// {dir[1:0], step[1:0]} are queued in a FIFO and executed one grid unit per
// clock. The cursor position is mirrored on led as {y, x}.
// Optional build macro: MOVE_WRAP_EN (coordinates wrap modulo 16 and bump
// never fires). When it is undefined, coordinates saturate at 0 and 15.
// Ports:
//   clk        in   system clock (posedge)
//   rst_n      in   synchronous active-low reset
//   cmd_valid  in   a command is offered this cycle
//   cmd        in   [3:2] dir (00 +x, 01 -x, 10 +y, 11 -y), [1:0] step 0..3
//   cmd_ready  out  FIFO not full
//   pause      in   freezes execution; the FIFO still accepts commands
//   led        out  registered {y[3:0], x[3:0]}
//   busy       out  queue non-empty or a command is in progress
//   done       out  1-cycle pulse on the edge that applies a command's last unit
//   bump       out  1-cycle pulse when a unit move is clipped at the grid edge
// ---------------------------------------------------------------------------
module move_sequencer
  import move_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  logic [CW-1:0] cmd,
  output logic          cmd_ready,
  input  logic          pause,
  output logic [7:0]    led,
  output logic          busy,
  output logic          done,
  output logic          bump
);

  state_e             state_r;
  logic [1:0]         dir_r;
  logic [1:0]         cnt_r;
  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CMD_W-1:0]   fifo_dout_s;
  cmd_t               head_s;
  logic               push_s;
  logic               pop_s;

  logic [COORD_W-1:0] nx_s;
  logic [COORD_W-1:0] ny_s;
  logic               clip_s;

  assign cmd_ready = !fifo_full_s;
  assign push_s    = cmd_valid && !fifo_full_s;
  assign head_s    = cmd_t'(fifo_dout_s);
  assign busy      = (state_r == ST_MOVE) || !fifo_empty_s;

  // Pop from IDLE, or on the final unit move of the current command so that
  // the next command starts on the following edge without a bubble.
  assign pop_s = !pause && !fifo_empty_s &&
                 ((state_r == ST_IDLE) ||
                  ((state_r == ST_MOVE) && (cnt_r == 2'd1)));

  move_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (cmd),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Candidate position after one unit move in dir_r; only one axis changes.
  always_comb begin
    nx_s   = x_r;
    ny_s   = y_r;
    clip_s = 1'b0;
    case (dir_r)
      DIR_XP:  {clip_s, nx_s} = unit_step(x_r, 1'b0);
      DIR_XN:  {clip_s, nx_s} = unit_step(x_r, 1'b1);
      DIR_YP:  {clip_s, ny_s} = unit_step(y_r, 1'b0);
      DIR_YN:  {clip_s, ny_s} = unit_step(y_r, 1'b1);
      default: begin
        nx_s   = x_r;
        ny_s   = y_r;
        clip_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM together with the position, led and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      dir_r   <= DIR_XP;
      cnt_r   <= 2'd0;
      x_r     <= 4'd0;
      y_r     <= 4'd0;
      led     <= 8'h00;
      done    <= 1'b0;
      bump    <= 1'b0;
    end else begin
      done <= 1'b0;
      bump <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            dir_r   <= head_s.dir;
            cnt_r   <= head_s.step;
            // A zero-step command is consumed here with no motion.
            state_r <= (head_s.step != 2'd0) ? ST_MOVE : ST_IDLE;
          end
        end
        ST_MOVE: begin
          if (!pause) begin
            x_r   <= nx_s;
            y_r   <= ny_s;
            led   <= {ny_s, nx_s};
            bump  <= clip_s;
            cnt_r <= cnt_r - 2'd1;
            if (cnt_r == 2'd1) begin
              done <= 1'b1;
              if (pop_s) begin
                dir_r   <= head_s.dir;
                cnt_r   <= head_s.step;
                state_r <= (head_s.step != 2'd0) ? ST_MOVE : ST_IDLE;
              end else begin
                state_r <= ST_IDLE;
              end
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// ---------------------------------------------------------------------------
// tb_move_sequencer
// Self-checking bench for move_sequencer. A queue-based behavioural model
// tracks the command queue, the remaining step count and the cursor position
// using integer arithmetic. Every edge, the bench compares led, done, bump,
// busy and cmd_ready with the model. The directed scenarios also check
// constant expectations.
// ---------------------------------------------------------------------------
module tb_move_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic       cmd_ready;
  logic       pause;
  logic [7:0] led;
  logic       busy;
  logic       done;
  logic       bump;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int mq[$];
  bit act;
  int rem;
  int mdir;
  int mx;
  int my;
  bit m_done;
  bit m_bump;

  move_sequencer #(.DEPTH(DEPTH), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .pause     (pause),
    .led       (led),
    .busy      (busy),
    .done      (done),
    .bump      (bump)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic start_cmd();
    int c;
    c    = mq.pop_front();
    mdir = (c >> 2) & 3;
    rem  = c & 3;
    act  = (rem != 0);
  endtask

  task automatic apply_unit();
    int dx;
    int dy;
    int nx;
    int ny;
    dx = 0;
    dy = 0;
    case (mdir)
      0: dx = 1;
      1: dx = -1;
      2: dy = 1;
      default: dy = -1;
    endcase
    nx = mx + dx;
    ny = my + dy;
`ifdef MOVE_WRAP_EN
    mx = nx & 15;
    my = ny & 15;
`else
    if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
      m_bump = 1'b1;
    end else begin
      mx = nx;
      my = ny;
    end
`endif
  endtask

  task automatic model_step(input logic r, input logic v, input logic [3:0] c, input logic p);
    bit acc;
    m_done = 1'b0;
    m_bump = 1'b0;
    if (!r) begin
      mq.delete();
      act = 1'b0;
      rem = 0;
      mx  = 0;
      my  = 0;
    end else begin
      acc = v && (mq.size() < DEPTH);
      if (!p) begin
        if (act) begin
          apply_unit();
          rem--;
          if (rem == 0) begin
            m_done = 1'b1;
            act    = 1'b0;
            if (mq.size() > 0) start_cmd();
          end
        end else if (mq.size() > 0) begin
          start_cmd();
        end
      end
      if (acc) mq.push_back(int'(c));
    end
  endtask

  // One clock: drive inputs, step the model on the edge, compare after it.
  task automatic tick(input logic r, input logic v, input logic [3:0] c, input logic p);
    rst_n     = r;
    cmd_valid = v;
    cmd       = c;
    pause     = p;
    #1;
    if (r) check_eq("cmd_ready", {31'd0, cmd_ready}, {31'd0, mq.size() < DEPTH});
    @(posedge clk);
    model_step(r, v, c, p);
    #1;
    check_eq("led",  {24'd0, led},  32'(my * 16 + mx));
    check_eq("done", {31'd0, done}, {31'd0, m_done});
    check_eq("bump", {31'd0, bump}, {31'd0, m_bump});
    check_eq("busy", {31'd0, busy}, {31'd0, act || (mq.size() > 0)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 4'd0, 1'b0);
    tick(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 4'd0;
    pause     = 1'b0;
    act = 1'b0; rem = 0; mdir = 0; mx = 0; my = 0; m_done = 1'b0; m_bump = 1'b0;

    // reset state
    do_reset();
    check_eq("rst_led",  {24'd0, led},  32'h00);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);

    // +x,3: led 01,02,03 starting two edges after the push
    tick(1'b1, 1'b1, 4'b0011, 1'b0);
    idle(1);
    check_eq("s1_led_t1", {24'd0, led}, 32'h00);
    idle(1);
    check_eq("s1_led_t2", {24'd0, led}, 32'h01);
    check_eq("s1_done_t2", {31'd0, done}, 32'd0);
    idle(1);
    check_eq("s1_led_t3", {24'd0, led}, 32'h02);
    idle(1);
    check_eq("s1_led_t4", {24'd0, led}, 32'h03);
    check_eq("s1_done_t4", {31'd0, done}, 32'd1);
    idle(1);
    check_eq("s1_busy_end", {31'd0, busy}, 32'd0);

    // edge behaviour: reach x=14, then +x,3
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 4'b0011, 1'b0);
    tick(1'b1, 1'b1, 4'b0010, 1'b0);
    idle(20);
    check_eq("s2_x14", {24'd0, led}, 32'h0E);
    tick(1'b1, 1'b1, 4'b0011, 1'b0);
    idle(6);
`ifdef MOVE_WRAP_EN
    check_eq("s2_wrap", {24'd0, led}, 32'h01);
`else
    check_eq("s2_sat", {24'd0, led}, 32'h0F);
`endif

    // paused fill: the fifth command is dropped, then four run back-to-back
    do_reset();
    tick(1'b1, 1'b1, 4'b0001, 1'b1);
    tick(1'b1, 1'b1, 4'b1010, 1'b1);
    tick(1'b1, 1'b1, 4'b0011, 1'b1);
    tick(1'b1, 1'b1, 4'b0101, 1'b1);
    check_eq("s3_full", {31'd0, cmd_ready}, 32'd0);
    tick(1'b1, 1'b1, 4'b1011, 1'b1);
    idle(12);
    check_eq("s3_final", {24'd0, led}, 32'h23);

    // zero-step command, then +y,1
    do_reset();
    tick(1'b1, 1'b1, 4'b1000, 1'b0);
    tick(1'b1, 1'b1, 4'b1001, 1'b0);
    idle(5);
    check_eq("s4_y1", {24'd0, led}, 32'h10);

    // -y,3 at y=0, then reset in the middle of +x,2
    do_reset();
    tick(1'b1, 1'b1, 4'b1111, 1'b0);
    idle(6);
    check_eq("s5_y0", {24'd0, led}, 32'h00);
    tick(1'b1, 1'b1, 4'b0010, 1'b0);
    idle(2);
    check_eq("s5_mid", {24'd0, led}, 32'h01);
    tick(1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("s5_rst_led",  {24'd0, led},  32'h00);
    check_eq("s5_rst_busy", {31'd0, busy}, 32'd0);
    idle(1);
    check_eq("s5_ready", {31'd0, cmd_ready}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic v;
      logic p;
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 99) < 55);
      p = ($urandom_range(0, 99) < 20);
      tick(r, v, 4'($urandom_range(0, 15)), p);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Command scheduler for the 4-bit x/y grid cursor driven by the rotary/LED lab datapath.
- Accepts move commands {dir[1:0], step[1:0]} into a small FIFO and executes them one grid unit per clock.
- Maintains cursor position and drives the 8 LEDs as {y, x}.
- Replaces the per-direction step fan-out with a single sequenced position register.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >= 2).
- CW, 4, command width {dir[1:0], step[1:0]}; fixed, do not override.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  command offered this cycle.
- cmd  input  4  [3:2] dir (00 +x, 01 -x, 10 +y, 11 -y); [1:0] step count 0..3.
- cmd_ready  output  1  FIFO not full.
- pause  input  1  freezes execution; FIFO still accepts.
- led  output  8  registered {y[3:0], x[3:0]}.
- busy  output  1  FIFO non-empty or state MOVE.
- done  output  1  one-cycle pulse on the edge that applies a command's last unit move.
- bump  output  1  one-cycle pulse when a unit move is clipped at the grid edge.

Behaviour:
- Reset (rst_n=0 at posedge): x=y=0, led=8'h00, FIFO emptied, state IDLE, busy=0, done=0, bump=0. cmd_ready=1 from the next cycle. Reset mid-MOVE aborts the command and discards all queued commands.
- FIFO:
  - cmd_ready = !full. Push on cmd_valid && cmd_ready.
  - No bypass: a pushed command is poppable at the earliest one cycle after the push edge.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - cmd_valid while full is ignored; the command is not stored.
- State machine:
  - IDLE: if !pause && !empty, pop the head and latch dir_r and cnt_r=step. Next state is MOVE if step!=0, else stay IDLE. A step=0 command is consumed with no motion and no done.
  - MOVE, pause=1: hold all registers.
  - MOVE, pause=0: apply one unit move in dir_r and decrement cnt_r.
    - If cnt_r was 1: assert done.
    - If FIFO non-empty in that cycle: pop the next head in the same cycle and stay MOVE (step!=0) or go IDLE (step=0). There is no bubble between commands.
    - Otherwise go IDLE.
- Latency: push at edge t0 into an empty, idle block gives pop at t1, first position change at t2, last change and done at t1+step.
- Arithmetic:
  - Default saturation: +x/+y at 15 and -x/-y at 0 leave the coordinate unchanged and pulse bump. cnt_r still decrements.
  - The non-moving axis never changes.
- led is updated on the same edge as the position register.
- busy = (state==MOVE) || !empty.

Optional Feature:
- Macro: MOVE_WRAP_EN.
- Defined: coordinates wrap modulo 16 (15+1=0, 0-1=15); bump is tied to 0.
- Undefined: saturating behaviour as above.

Decomposition:
- Shared package move_pkg:
  - dir encodings DIR_XP=2'b00, DIR_XN=2'b01, DIR_YP=2'b10, DIR_YN=2'b11;
  - state encoding ST_IDLE, ST_MOVE;
  - CMD_W=4, COORD_W=4.
- One sub-module move_cmd_fifo: parameter DEPTH, synchronous active-low reset, ports push/pop/din/dout/full/empty.
- The FSM and position datapath stay in move_sequencer.

Test Plan:
- Reset, push cmd=4'b0011 (+x,3) → led 8'h01, 8'h02, 8'h03 on consecutive cycles starting 2 cycles after push; done high only with 8'h03; busy falls the next cycle.
- Reach x=14, push 4'b0011 → x=15 then held; bump pulses on the last two moves; with MOVE_WRAP_EN x=15, 0, 1 and bump stays 0.
- pause=1, push 5 commands → cmd_ready=0 after the 4th and the 5th is dropped; release pause → 4 commands run back-to-back with no idle cycle, final led matches the summed moves.
- Push 4'b1000 (+y,0) then 4'b1001 → first consumed with no motion and no done; y becomes 1 with a single done.
- Push 4'b1111 (-y,3) from y=0 → y stays 0 with 3 bump pulses; then +x,2 mid-command with rst_n=0 → next edge led=8'h00, busy=0, queue empty.
- Push while popping at occupancy 3 → occupancy stays 3, cmd_ready stays 1, execution order preserved.
